// File: rtl/ppg_afe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppg_afe_pkg
//  Brief    : Shared state encoding and ADC level helpers for the PPG AFE
//             calibrator.
//  Revision : 1.0  initial release
// ============================================================================
package ppg_afe_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DC_SEARCH   = 3'd1,
        S_GAIN_SEARCH = 3'd2,
        S_NEXT_CH     = 3'd3,
        S_RUN         = 3'd4
    } state_t;

    function automatic logic [31:0] adc_mid(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] adc_full(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // A sample clips when it sits on either rail of the converter.
    function automatic logic is_clip(input logic [31:0] s, input int w);
        return (s == 32'd0) || (s == adc_full(w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/afe_sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : afe_sar_search
//  Brief    : MSB-first successive-approximation search; code_nxt exposes the
//             next trial so the caller can register it without extra latency.
//  Revision : 1.0  initial release
// ============================================================================
module afe_sar_search #(
    parameter int DC_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            strobe,
    input  logic            keep,
    output logic [DC_W-1:0] code_nxt,
    output logic            done
);

    localparam logic [DC_W-1:0] C_MSB = DC_W'(1) << (DC_W - 1);

    logic [DC_W-1:0] r_code;
    logic [DC_W-1:0] r_mask;
    logic [DC_W-1:0] w_mask_nxt;
    logic [DC_W-1:0] w_decided;

    always_comb begin
        code_nxt   = r_code;
        w_mask_nxt = r_mask;
        w_decided  = keep ? r_code : (r_code & ~r_mask);
        done       = strobe && r_mask[0];
        if (load) begin
            code_nxt   = C_MSB;
            w_mask_nxt = C_MSB;
        end else if (strobe) begin
            w_mask_nxt = r_mask >> 1;
            code_nxt   = w_decided | (r_mask >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_mask <= '0;
        end else begin
            r_code <= code_nxt;
            r_mask <= w_mask_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppg_afe_calibrator.sv
`default_nettype none
// ============================================================================
//  Module   : ppg_afe_calibrator
//  Brief    : Per-LED DC-comp SAR and PGA gain calibration, then round-robin
//             LED multiplexing with channel-tagged sample forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module ppg_afe_calibrator
    import ppg_afe_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int ADC_W       = 8,
    parameter int DC_W        = 7,
    parameter int GAIN_W      = 4,
    parameter int GAIN_MAX    = 7,
    parameter int PGA_SAMPLES = 1000,
    parameter int DWELL       = 10,
    parameter int SETTLE      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [ADC_W-1:0]                        adc,
    input  logic                                    adc_valid,
    output logic [DC_W-1:0]                         dc_comp,
    output logic [GAIN_W-1:0]                       pga_gain,
    output logic [N_CH-1:0]                         led_en,
    output logic                                    busy,
    output logic                                    cal_done,
    output logic [N_CH-1:0]                         cal_error,
    output logic [ADC_W-1:0]                        sample_out,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] sample_ch,
    output logic                                    sample_valid
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(SETTLE + PGA_SAMPLES + DWELL + 1);
    localparam logic [CNT_W-1:0]  C_SETTLE    = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  C_WIN_LAST  = CNT_W'(SETTLE + PGA_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  C_SLOT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CH_W-1:0]   C_CH_LAST   = CH_W'(N_CH - 1);

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clip;
    logic [DC_W-1:0]    r_dc_mem   [N_CH];
    logic [GAIN_W-1:0]  r_gain_mem [N_CH];

    logic [31:0]        w_adc32;
    logic               w_above;
    logic               w_clip;
    logic               w_win_clip;
    logic               w_last_ch;
    logic [CH_W-1:0]    w_ch_wrap;
    logic               w_sar_load;
    logic               w_sar_strobe;
    logic               w_sar_done;
    logic [DC_W-1:0]    w_sar_next;

    assign w_adc32      = 32'(adc);
    assign w_above      = w_adc32 > adc_mid(ADC_W);
    assign w_clip       = is_clip(w_adc32, ADC_W);
    assign w_win_clip   = r_clip | w_clip;
    assign w_last_ch    = (r_ch == C_CH_LAST);
    assign w_ch_wrap    = w_last_ch ? '0 : r_ch + 1'b1;
    assign w_sar_load   = (start && (r_state == S_IDLE || r_state == S_RUN)) ||
                          (r_state == S_NEXT_CH && !w_last_ch);
    assign w_sar_strobe = (r_state == S_DC_SEARCH) && adc_valid && (r_cnt == C_SETTLE);

    afe_sar_search #(
        .DC_W (DC_W)
    ) u_sar (
        .clk      (clk),
        .rst      (rst),
        .load     (w_sar_load),
        .strobe   (w_sar_strobe),
        .keep     (w_above),
        .code_nxt (w_sar_next),
        .done     (w_sar_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_cnt        <= '0;
            r_clip       <= 1'b0;
            dc_comp      <= '0;
            pga_gain     <= '0;
            led_en       <= '0;
            busy         <= 1'b0;
            cal_done     <= 1'b0;
            cal_error    <= '0;
            sample_out   <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_dc_mem[i]   <= '0;
                r_gain_mem[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DC_SEARCH;
                        r_ch    <= '0;
                        r_cnt   <= '0;
                        led_en  <= N_CH'(1);
                        busy    <= 1'b1;
                        dc_comp <= w_sar_next;
                    end
                end
                S_DC_SEARCH: begin
                    if (adc_valid) begin
                        if (r_cnt == C_SETTLE) begin
                            r_cnt   <= '0;
                            dc_comp <= w_sar_next;
                            if (w_sar_done) begin
                                r_dc_mem[r_ch] <= w_sar_next;
                                pga_gain       <= GAIN_W'(GAIN_MAX);
                                r_clip         <= 1'b0;
                                r_state        <= S_GAIN_SEARCH;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_GAIN_SEARCH: begin
                    if (adc_valid) begin
                        if (r_cnt == C_WIN_LAST) begin
                            r_cnt  <= '0;
                            r_clip <= 1'b0;
                            if (w_win_clip && pga_gain != '0) begin
                                pga_gain <= pga_gain - 1'b1;
                            end else begin
                                r_gain_mem[r_ch] <= pga_gain;
                                if (w_win_clip) cal_error[r_ch] <= 1'b1;
                                r_state <= S_NEXT_CH;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            // Samples still inside the settle blanking never count as clips.
                            if (r_cnt >= C_SETTLE && w_clip) r_clip <= 1'b1;
                        end
                    end
                end
                S_NEXT_CH: begin
                    r_cnt <= '0;
                    if (!w_last_ch) begin
                        r_ch    <= r_ch + 1'b1;
                        led_en  <= led_en << 1;
                        dc_comp <= w_sar_next;
                        r_state <= S_DC_SEARCH;
                    end else begin
                        r_ch     <= '0;
                        led_en   <= N_CH'(1);
                        dc_comp  <= r_dc_mem[0];
                        pga_gain <= r_gain_mem[0];
                        busy     <= 1'b0;
                        cal_done <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        r_state   <= S_DC_SEARCH;
                        r_ch      <= '0;
                        r_cnt     <= '0;
                        led_en    <= N_CH'(1);
                        busy      <= 1'b1;
                        cal_done  <= 1'b0;
                        cal_error <= '0;
                        dc_comp   <= w_sar_next;
                    end else if (adc_valid) begin
                        if (r_cnt >= C_SETTLE) begin
                            sample_valid <= 1'b1;
                            sample_out   <= adc;
                            sample_ch    <= r_ch;
                        end
                        if (r_cnt == C_SLOT_LAST) begin
                            r_cnt    <= '0;
                            r_ch     <= w_ch_wrap;
                            led_en   <= N_CH'(1) << w_ch_wrap;
                            dc_comp  <= r_dc_mem[w_ch_wrap];
                            pga_gain <= r_gain_mem[w_ch_wrap];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppg_afe_calibrator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppg_afe_calibrator
//  Brief    : Scoreboard bench; expected settings and forwarded samples come
//             from a sample-level model of the calibration and RUN rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppg_afe_calibrator;

    localparam int N_CH = 2, ADC_W = 8, DC_W = 7, GAIN_W = 4, GAIN_MAX = 7;
    localparam int PGA_SAMPLES = 8, DWELL = 10, SETTLE = 1;

    logic              clk, rst, start, adc_valid;
    logic [ADC_W-1:0]  adc;
    logic [DC_W-1:0]   dc_comp;
    logic [GAIN_W-1:0] pga_gain;
    logic [N_CH-1:0]   led_en, cal_error;
    logic              busy, cal_done, sample_valid;
    logic [ADC_W-1:0]  sample_out;
    logic [0:0]        sample_ch;

    ppg_afe_calibrator #(
        .N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .GAIN_W(GAIN_W), .GAIN_MAX(GAIN_MAX),
        .PGA_SAMPLES(PGA_SAMPLES), .DWELL(DWELL), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .adc(adc), .adc_valid(adc_valid),
        .dc_comp(dc_comp), .pga_gain(pga_gain), .led_en(led_en), .busy(busy),
        .cal_done(cal_done), .cal_error(cal_error), .sample_out(sample_out),
        .sample_ch(sample_ch), .sample_valid(sample_valid)
    );

    typedef struct { int dc; int gain; bit chkg; int led; } set_t;
    typedef struct { int val; int ch; } out_t;

    set_t set_q[$];
    out_t out_q[$];
    int   checks = 0, errors = 0;
    bit   track = 0, gaps = 0;
    int   tgt[N_CH], lim[N_CH], exp_dc[N_CH], exp_gain[N_CH];
    int   exp_err;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: settings seen while a sample is offered, and every forwarded sample.
    always @(negedge clk) begin
        if (track && adc_valid) begin
            if (set_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL settings_queue actual=empty expected=entry at %0t", $time);
            end else begin
                set_t e;
                e = set_q.pop_front();
                chk("dc_comp", int'(dc_comp), e.dc);
                chk("led_en", int'(led_en), e.led);
                if (e.chkg) chk("pga_gain", int'(pga_gain), e.gain);
            end
        end
        if (track && sample_valid) begin
            if (out_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sample_queue actual=empty expected=entry at %0t", $time);
            end else begin
                out_t o;
                o = out_q.pop_front();
                chk("sample_out", int'(sample_out), o.val);
                chk("sample_ch", int'(sample_ch), o.ch);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic send(input int a);
        if (gaps) idle($urandom_range(0, 2));
        adc = ADC_W'(a);
        adc_valid = 1'b1;
        idle(1);
        adc_valid = 1'b0;
    endtask

    task automatic do_sample(input int dc, input int gain, input bit chkg, input int ch,
                             input int a, input bit fwd);
        set_t e;
        out_t o;
        e.dc = dc; e.gain = gain; e.chkg = chkg; e.led = 1 << ch;
        set_q.push_back(e);
        if (fwd) begin
            o.val = a; o.ch = ch;
            out_q.push_back(o);
        end
        send(a);
    endtask

    function automatic int dc_model(input int ch, input int dc);
        int v;
        v = 128 + 4 * (tgt[ch] - dc);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_dc_comp"}, int'(dc_comp), 0);
        chk({tag, "_pga_gain"}, int'(pga_gain), 0);
        chk({tag, "_led_en"}, int'(led_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cal_done"}, int'(cal_done), 0);
        chk({tag, "_cal_error"}, int'(cal_error), 0);
        chk({tag, "_sample_out"}, int'(sample_out), 0);
        chk({tag, "_sample_ch"}, int'(sample_ch), 0);
        chk({tag, "_sample_valid"}, int'(sample_valid), 0);
    endtask

    task automatic check_started();
        chk("start_busy", int'(busy), 1);
        chk("start_cal_done", int'(cal_done), 0);
        chk("start_cal_error", int'(cal_error), 0);
        chk("start_dc_trial", int'(dc_comp), 1 << (DC_W - 1));
        chk("start_led", int'(led_en), 1);
    endtask

    // SAR per channel, then gain walk-down until a window is clean or gain 0 clips.
    task automatic calibrate();
        int  res, trial, a, g, p;
        bit  clip, fin;
        exp_err = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            res = 0;
            a = 0;
            for (int b = DC_W - 1; b >= 0; b--) begin
                trial = res | (1 << b);
                for (int s = 0; s <= SETTLE; s++) begin
                    a = dc_model(ch, trial);
                    do_sample(trial, 0, 1'b0, ch, a, 1'b0);
                end
                if (a > 127) res = trial;
            end
            exp_dc[ch] = res;
            if (gaps && ch == 0) begin
                pulse_start();
                chk("start_ignored_busy", int'(busy), 1);
            end
            g = GAIN_MAX;
            fin = 1'b0;
            while (!fin) begin
                clip = g > lim[ch];
                for (int s = 0; s < SETTLE; s++)
                    do_sample(res, g, 1'b1, ch, $urandom_range(0, 255), 1'b0);
                p = $urandom_range(0, PGA_SAMPLES - 1);
                for (int w = 0; w < PGA_SAMPLES; w++) begin
                    if (clip && lim[ch] < 0) a = 255;
                    else if (clip && w == p) a = ($urandom_range(0, 1) == 1) ? 255 : 0;
                    else a = $urandom_range(1, 254);
                    do_sample(res, g, 1'b1, ch, a, 1'b0);
                end
                if (!clip) fin = 1'b1;
                else if (g == 0) begin exp_err |= (1 << ch); fin = 1'b1; end
                else g--;
            end
            exp_gain[ch] = g;
            idle(1);
        end
        chk("cal_busy", int'(busy), 0);
        chk("cal_done", int'(cal_done), 1);
        chk("cal_error", int'(cal_error), exp_err);
    endtask

    task automatic run(input int nsamp);
        int slot, ch, s;
        for (int i = 0; i < nsamp; i++) begin
            slot = i / DWELL;
            ch   = slot % N_CH;
            s    = i % DWELL;
            do_sample(exp_dc[ch], exp_gain[ch], 1'b1, ch, $urandom_range(0, 255), s >= SETTLE);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; adc = '0; adc_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        check_zero("reset");
        for (int i = 0; i < 20; i++) begin
            adc_valid = 1'(($urandom_range(0, 1)));
            adc = ADC_W'($urandom_range(0, 255));
            idle(1);
            check_zero("idle");
        end
        adc_valid = 1'b0;
        track = 1'b1;

        tgt[0] = 40; tgt[1] = 100; lim[0] = 4; lim[1] = -1;
        pulse_start();
        check_started();
        calibrate();
        run(4 * DWELL + 3);
        idle(3);

        pulse_start();
        check_started();
        gaps = 1'b1;
        calibrate();
        run(5 * DWELL);
        idle(3);

        pulse_start();
        do_sample(64, 0, 1'b0, 0, dc_model(0, 64), 1'b0);
        do_sample(64, 0, 1'b0, 0, dc_model(0, 64), 1'b0);
        do_sample(32, 0, 1'b0, 0, dc_model(0, 32), 1'b0);
        rst = 1'b1; start = 1'b1;
        idle(1);
        rst = 1'b0; start = 1'b0;
        check_zero("midrst");
        idle(2);
        check_zero("postrst");

        tgt[0] = 17; tgt[1] = 90; lim[0] = 2; lim[1] = 5;
        pulse_start();
        check_started();
        calibrate();
        run(3 * DWELL + 4);
        idle(4);

        chk("settings_left", set_q.size(), 0);
        chk("samples_left", out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
